// File: rtl/fdd_mech.sv
// fdd_mech: multi-drive floppy mechanics (motor, head stepping, rotation/index), muxed by USEL.
// Optional disk-change latch enabled by defining FDD_MECH_DISKCHANGE_EN.
module fdd_mech #(
  parameter int DRIVES     = 4,
  parameter int MAX_TRACKS = 80,
  parameter int SPINUP_MS  = 500,
  parameter int TIMEOUT_MS = 30000,
  parameter int STEP_MS    = 3,
  parameter int INDEX_MS   = 2,
  localparam int W = DRIVES > 1 ? $clog2(DRIVES) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              msclk,
  input  logic [W-1:0]      USEL,
  input  logic [DRIVES-1:0] MOTORn,
  input  logic              STEPn,
  input  logic              SDIRn,
  input  logic [DRIVES-1:0] disk_present,
  input  logic [DRIVES-1:0] speed,
  output logic              READYn,
  output logic              INDEXn,
  output logic              TRACK0n,
  output logic              DSKCHGn,
  output logic [6:0]        track,
  output logic              seek_busy,
  output logic [DRIVES-1:0] motor_run
);
  localparam int MX = SPINUP_MS > TIMEOUT_MS ? SPINUP_MS : TIMEOUT_MS;
  localparam int CW = $clog2(MX + 1);
  localparam int BW = $clog2(STEP_MS + 1);
  localparam logic [6:0] TMAX = 7'(MAX_TRACKS - 1);
  typedef enum logic [1:0] {OFF, SPINUP, RUN} mstate_t;
  mstate_t           st    [DRIVES];
  logic [CW-1:0]     cnt   [DRIVES];
  logic [7:0]        phase [DRIVES];
  logic [6:0]        trk   [DRIVES];
  logic [BW-1:0]     busy  [DRIVES];
  logic [DRIVES-1:0] idx;
  logic [DRIVES-1:0] hit;
  logic              step_q;
  logic              step_edge;
  assign step_edge = !STEPn && step_q;
  for (genvar i = 0; i < DRIVES; i++) begin : g_drv
    logic [7:0] period;
    assign period = speed[i] ? 8'd167 : 8'd200;
    assign hit[i] = step_edge && USEL == W'(i) && busy[i] == '0;
    assign idx[i] = st[i] == RUN && disk_present[i] && phase[i] < 8'(INDEX_MS);
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        st[i]    <= OFF;
        cnt[i]   <= '0;
        phase[i] <= '0;
        trk[i]   <= '0;
        busy[i]  <= '0;
      end else begin
        if (st[i] == OFF) begin
          if (!MOTORn[i]) begin
            st[i]  <= SPINUP;
            cnt[i] <= CW'(SPINUP_MS);
          end
        end else if (st[i] == SPINUP) begin
          if (MOTORn[i]) st[i] <= OFF;
          else if (cnt[i] == '0) begin
            st[i]  <= RUN;
            cnt[i] <= CW'(TIMEOUT_MS);
          end else if (msclk) cnt[i] <= cnt[i] - CW'(1);
        end else begin
          if (!MOTORn[i]) cnt[i] <= CW'(TIMEOUT_MS);
          else if (cnt[i] == '0) st[i] <= OFF;
          else if (msclk) cnt[i] <= cnt[i] - CW'(1);
        end
        // out-of-range phase (after a speed change) wraps without waiting for msclk
        phase[i] <= st[i] != RUN || phase[i] >= period ? 8'd0 :
                    msclk ? (phase[i] == period - 8'd1 ? 8'd0 : phase[i] + 8'd1) : phase[i];
        if (hit[i]) begin
          trk[i]  <= SDIRn ? (trk[i] == 7'd0 ? 7'd0 : trk[i] - 7'd1) :
                             (trk[i] >= TMAX ? TMAX : trk[i] + 7'd1);
          busy[i] <= BW'(STEP_MS);
        end else if (msclk && busy[i] != '0) busy[i] <= busy[i] - BW'(1);
      end
  end
`ifdef FDD_MECH_DISKCHANGE_EN
  logic [DRIVES-1:0] dchg;
  logic [DRIVES-1:0] dp_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      dchg <= '1;
      dp_q <= '0;
    end else begin
      dchg <= (dp_q ^ disk_present) | (dchg & ~(hit & disk_present));
      dp_q <= disk_present;
    end
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      step_q    <= 1'b1;
      READYn    <= 1'b1;
      INDEXn    <= 1'b1;
      TRACK0n   <= 1'b0;
      DSKCHGn   <= 1'b1;
      track     <= '0;
      seek_busy <= 1'b0;
      motor_run <= '0;
    end else begin
      step_q    <= STEPn;
      READYn    <= !(st[USEL] == RUN && disk_present[USEL]);
      INDEXn    <= !idx[USEL];
      TRACK0n   <= trk[USEL] != 7'd0;
      track     <= trk[USEL];
      seek_busy <= busy[USEL] != '0;
`ifdef FDD_MECH_DISKCHANGE_EN
      DSKCHGn   <= !dchg[USEL];
`else
      DSKCHGn   <= 1'b1;
`endif
      for (int k = 0; k < DRIVES; k++) motor_run[k] <= st[k] == RUN;
    end
endmodule
